// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, column seed and one-hot-low decoding for the hex keypad
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, PRESS_DB, ACCEPT, RELEASE_DB} state_e;
    localparam logic [3:0] COL_INIT = 4'b1110;
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } onehot_t;
    function automatic onehot_t onehot_low_index(input logic [3:0] v);
        onehot_t r;
        r.valid = 1'b0;
        r.idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v == ~(4'b0001 << i)) begin
                r.valid = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/keypad_sync_div.sv
// keypad_sync_div: two-flop row synchronizer and scan divider producing the sample pulse
module keypad_sync_div #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] row_s,
    output logic       sample
);
    localparam int DW = $clog2(SCAN_DIV);
    logic [3:0]    r1_q, r2_q;
    logic [DW-1:0] div_q, div_d;
    assign sample = div_q == DW'(SCAN_DIV - 1);
    assign div_d  = sample ? '0 : div_q + DW'(1);
    assign row_s  = r2_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r1_q  <= 4'hF;
            r2_q  <= 4'hF;
            div_q <= '0;
        end else begin
            r1_q  <= row;
            r2_q  <= r1_q;
            div_q <= div_d;
        end
    end
endmodule

// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: scans and debounces a 4x4 keypad, shifting accepted key codes into a 16-bit entry
module hex_keypad_entry #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] number,
    output logic        busy
);
    import keypad_pkg::*;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    state_e        state_q, state_d;
    logic [3:0]    col_q, col_d, key_code_q, key_code_d, row_s, col_rot;
    logic [15:0]   number_q, number_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          key_valid_q, sample, held_row, released, db_done;
    onehot_t       row_hit, col_hit;

    keypad_sync_div #(.SCAN_DIV(SCAN_DIV)) u_sync_div (
        .clk    (clk),
        .reset  (reset),
        .row    (row),
        .row_s  (row_s),
        .sample (sample)
    );

    assign row_hit  = onehot_low_index(row_s);
    assign col_hit  = onehot_low_index(col_q);
    assign col_rot  = {col_q[2:0], col_q[3]};
    assign cnt_inc  = cnt_q + CW'(1);
    assign db_done  = cnt_inc == CW'(DEBOUNCE_SCANS);
    assign held_row = row_s == ~(4'b0001 << row_idx_q);
    assign released = row_s == 4'hF;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        key_code_d = key_code_q;
        number_d   = number_q;
        row_idx_d  = row_idx_q;
        cnt_d      = cnt_q;
        case (state_q)
            SCAN: if (sample) begin
                if (row_hit.valid) begin
                    row_idx_d = row_hit.idx;
                    cnt_d     = '0;
                    state_d   = PRESS_DB;
                end else begin
                    col_d = col_rot;
                end
            end
            PRESS_DB: if (sample) begin
                if (held_row) begin
                    cnt_d   = cnt_inc;
                    state_d = db_done ? ACCEPT : PRESS_DB;
                end else begin
                    state_d = SCAN;
                    col_d   = col_rot;
                end
            end
            ACCEPT: begin
                key_code_d = {row_idx_q, col_hit.idx};
                number_d   = {number_q[11:0], row_idx_q, col_hit.idx};
                cnt_d      = '0;
                state_d    = RELEASE_DB;
            end
            RELEASE_DB: if (sample) begin
                cnt_d = released ? cnt_inc : '0;
                if (released && db_done) begin
                    state_d = SCAN;
                    col_d   = col_rot;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SCAN;
            col_q       <= COL_INIT;
            key_code_q  <= 4'h0;
            number_q    <= 16'h0000;
            row_idx_q   <= 2'd0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            number_q    <= number_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            key_valid_q <= state_q == ACCEPT;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign number    = number_q;
    assign busy      = state_q != SCAN;
endmodule

// File: tb/tb_hex_keypad_entry.sv
// tb_hex_keypad_entry: directed checks of the keypad entry against a switch-matrix keypad model
module tb_hex_keypad_entry;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row, col, key_code;
    logic        key_valid, busy;
    logic [15:0] number;
    logic [15:0] keys = 16'h0;
    int          checks = 0, errors = 0, pulses = 0, bad_col = 0;

    hex_keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .number    (number),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) pulses++;
        if (!(col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad_col++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int code, input int hold);
        keys = 16'h0;
        keys[code] = 1'b1;
        cycles(hold);
        keys = 16'h0;
        cycles(40);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycles(3);
        reset = 1'b1;
    endtask

    initial begin
        int          base;
        logic [3:0]  prev, seen;
        logic        busy_seen;
        logic [15:0] exp_num [5] = '{16'h0001, 16'h001A, 16'h01A3, 16'h1A3F, 16'hA3F5};
        int          codes [5] = '{1, 10, 3, 15, 5};
        cycles(3);
        check("rst_col", {12'h0, col}, 16'h000E);
        check("rst_code", {12'h0, key_code}, 16'h0);
        check("rst_valid", {15'h0, key_valid}, 16'h0);
        check("rst_number", number, 16'h0);
        check("rst_busy", {15'h0, busy}, 16'h0);
        reset = 1'b1;
        // test 1: key (1,2) held cleanly
        keys[6] = 1'b1;
        cycles(200);
        keys = 16'h0;
        cycles(1);
        check("t1_busy_held", {15'h0, busy}, 16'h1);
        cycles(30);
        check("t1_pulses", 16'(pulses), 16'd1);
        check("t1_code", {12'h0, key_code}, 16'h6);
        check("t1_number", number, 16'h0006);
        check("t1_busy_idle", {15'h0, busy}, 16'h0);
        // test 2: five-key entry with wrap
        do_reset();
        base = pulses;
        for (int i = 0; i < 5; i++) begin
            press(codes[i], 60);
            check($sformatf("t2_number%0d", i), number, exp_num[i]);
            check($sformatf("t2_code%0d", i), {12'h0, key_code}, 16'(codes[i]));
        end
        check("t2_pulses", 16'(pulses - base), 16'd5);
        // test 3: bounce shorter than the debounce window
        base = pulses;
        for (int i = 0; i < 3; i++) begin
            keys[0] = 1'b1;
            cycles(3);
            keys = 16'h0;
            cycles(20);
        end
        check("t3_pulses", 16'(pulses - base), 16'd0);
        check("t3_number", number, 16'hA3F5);
        check("t3_busy", {15'h0, busy}, 16'h0);
        // test 4: two rows in one column are ignored
        base = pulses;
        keys[9] = 1'b1;
        keys[13] = 1'b1;
        prev = col;
        seen = 4'h0;
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            busy_seen |= busy;
            seen |= ~col;
            if (col != prev) check("t4_rot", {12'h0, col}, {12'h0, prev[2:0], prev[3]});
            prev = col;
        end
        keys = 16'h0;
        check("t4_seen", {12'h0, seen}, 16'h000F);
        check("t4_busy", {15'h0, busy_seen}, 16'h0);
        check("t4_pulses", 16'(pulses - base), 16'd0);
        cycles(20);
        // test 5: reset while debouncing a press
        keys[3] = 1'b1;
        for (int i = 0; i < 100 && !busy; i++) cycles(1);
        check("t5_busy", {15'h0, busy}, 16'h1);
        reset = 1'b0;
        cycles(1);
        check("t5_col", {12'h0, col}, 16'h000E);
        check("t5_number", number, 16'h0);
        check("t5_valid", {15'h0, key_valid}, 16'h0);
        check("t5_rbusy", {15'h0, busy}, 16'h0);
        reset = 1'b1;
        base = pulses;
        cycles(100);
        keys = 16'h0;
        cycles(40);
        check("t5_pulses", 16'(pulses - base), 16'd1);
        check("t5_code", {12'h0, key_code}, 16'h3);
        check("t5_number2", number, 16'h0003);
        // test 6: long hold with a short release glitch
        base = pulses;
        keys[15] = 1'b1;
        cycles(1000);
        keys = 16'h0;
        cycles(2);
        keys[15] = 1'b1;
        cycles(100);
        check("t6_glitch_pulses", 16'(pulses - base), 16'd1);
        check("t6_glitch_number", number, 16'h003F);
        keys = 16'h0;
        cycles(40);
        press(15, 60);
        check("t6_pulses", 16'(pulses - base), 16'd2);
        check("t6_number", number, 16'h03FF);
        check("col_onehot", 16'(bad_col), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
